// File: rtl/phy_tx_lane_sched_pkg.sv
// Shared PHY definitions: comma symbol, preamble length, scheduler state encoding.
package phy_tx_lane_sched_pkg;

  // Comma/idle symbol; the receive deserializer aligns on the same byte.
  localparam logic [7:0] PHY_IDLE_CHAR  = 8'hBC;

  // Preamble length; the receiver's comma threshold uses the same value.
  localparam int         PHY_SYNC_COUNT = 4;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } phy_state_e;

  // Increment with wrap at n, used for round-robin pointer advance.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/phy_tx_lane_sched_if.sv
// Lane request bus plus serializer-side outputs of the transmit scheduler.
interface phy_tx_lane_sched_if #(
  parameter int N_LANES = 4
);

  logic [8*N_LANES-1:0] data_in;
  logic [N_LANES-1:0]   valid_in;
  logic                 resync;
  logic [N_LANES-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic [2:0]           tx_lane;
  logic                 active;
  logic                 err_comma;

  // Requesters and control: drive lanes and resync, observe the scheduler.
  modport master (
    output data_in, valid_in, resync,
    input  grant, tx_data, tx_valid, tx_lane, active, err_comma
  );

  // The scheduler itself.
  modport slave (
    input  data_in, valid_in, resync,
    output grant, tx_data, tx_valid, tx_lane, active, err_comma
  );

endinterface

// File: rtl/phy_tx_lane_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module phy_rr_pick #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int k;
    // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[PTR_W'(k)]) begin
        any             = 1'b1;
        gnt[PTR_W'(k)]  = 1'b1;
        gnt_idx         = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/phy_tx_lane_sched.sv
// Transmit lane scheduler: comma preamble, round-robin lane sharing, idle insertion.
module phy_tx_lane_sched
  import phy_tx_lane_sched_pkg::*;
#(
  parameter int         N_LANES    = 4,
  parameter int         SYNC_COUNT = PHY_SYNC_COUNT,
  parameter int         MAX_RUN    = 16,
  parameter logic [7:0] IDLE_CHAR  = PHY_IDLE_CHAR
) (
  input logic                  clk_4f,
  input logic                  reset,
  phy_tx_lane_sched_if.slave   bus
);

  localparam int PTR_W  = $clog2(N_LANES);
  localparam int SYNC_W = $clog2(SYNC_COUNT + 1);
  localparam int RUN_W  = $clog2(MAX_RUN + 2);

  phy_state_e        state_q,     state_d;
  logic [SYNC_W-1:0] sync_cnt_q,  sync_cnt_d;
  logic [RUN_W-1:0]  run_cnt_q,   run_cnt_d;
  logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [7:0]        tx_data_q,   tx_data_d;
  logic              tx_valid_q,  tx_valid_d;
  logic [2:0]        tx_lane_q,   tx_lane_d;
  logic              active_q,    active_d;
  logic              err_comma_q, err_comma_d;

  logic               forced;
  logic [N_LANES-1:0] pick_req;
  logic [N_LANES-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [7:0]         pick_byte;

  // A full run of data bytes forces one idle so the far end keeps alignment.
  assign forced    = (MAX_RUN != 0) && (run_cnt_q == RUN_W'(MAX_RUN));
  assign pick_req  = (state_q == ST_RUN && !forced && !bus.resync) ? bus.valid_in : '0;
  assign pick_byte = bus.data_in[{pick_idx, 3'b000} +: 8];

  phy_rr_pick #(.N(N_LANES)) u_pick (
    .req     (pick_req),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign bus.grant     = pick_gnt;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_lane   = tx_lane_q;
  assign bus.active    = active_q;
  assign bus.err_comma = err_comma_q;

  // Next state and next outputs: resync first, then preamble, then grant/idle.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    run_cnt_d   = run_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_lane_d   = tx_lane_q;
    active_d    = active_q;
    err_comma_d = err_comma_q;

    if (bus.resync) begin
      state_d    = ST_SYNC;
      sync_cnt_d = '0;
      run_cnt_d  = '0;
      active_d   = 1'b0;
      tx_data_d  = IDLE_CHAR;
      tx_valid_d = 1'b0;
    end else if (state_q == ST_SYNC) begin
      tx_data_d  = IDLE_CHAR;
      tx_valid_d = 1'b0;
      sync_cnt_d = sync_cnt_q + 1'b1;
      if (sync_cnt_q == SYNC_W'(SYNC_COUNT - 1)) begin
        state_d    = ST_RUN;
        active_d   = 1'b1;
        sync_cnt_d = '0;
      end
    end else if (pick_any) begin
      rr_ptr_d  = PTR_W'(wrap_inc(int'(pick_idx), N_LANES));
      tx_lane_d = 3'(pick_idx);
      if (pick_byte == IDLE_CHAR) begin
        // A comma offered as data is swallowed: sending it would mis-align the receiver.
        tx_data_d   = IDLE_CHAR;
        tx_valid_d  = 1'b0;
        err_comma_d = 1'b1;
        run_cnt_d   = '0;
      end else begin
        tx_data_d  = pick_byte;
        tx_valid_d = 1'b1;
        run_cnt_d  = run_cnt_q + 1'b1;
      end
    end else begin
      tx_data_d  = IDLE_CHAR;
      tx_valid_d = 1'b0;
      run_cnt_d  = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      run_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      tx_data_q   <= IDLE_CHAR;
      tx_valid_q  <= 1'b0;
      tx_lane_q   <= '0;
      active_q    <= 1'b0;
      err_comma_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      run_cnt_q   <= run_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_lane_q   <= tx_lane_d;
      active_q    <= active_d;
      err_comma_q <= err_comma_d;
    end
  end

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Bench for phy_tx_lane_sched: two instances (MAX_RUN=16 and MAX_RUN=0) share stimulus;
// a cycle model feeds a scoreboard queue and directed checks cover the key sequences.
module tb_phy_tx_lane_sched;
  import phy_tx_lane_sched_pkg::*;

  localparam int N  = 4;
  localparam int SC = PHY_SYNC_COUNT;
  localparam logic [7:0] BC = PHY_IDLE_CHAR;

  logic clk_4f = 1'b0;
  logic reset;
  logic [8*N-1:0] din;
  logic [N-1:0]   vin;
  logic           rsy;

  always #5 clk_4f = ~clk_4f;

  phy_tx_lane_sched_if #(.N_LANES(N)) bus_a ();
  phy_tx_lane_sched_if #(.N_LANES(N)) bus_b ();

  assign bus_a.data_in  = din;
  assign bus_a.valid_in = vin;
  assign bus_a.resync   = rsy;
  assign bus_b.data_in  = din;
  assign bus_b.valid_in = vin;
  assign bus_b.resync   = rsy;

  phy_tx_lane_sched #(.N_LANES(N), .SYNC_COUNT(SC), .MAX_RUN(16)) u_dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_a)
  );

  phy_tx_lane_sched #(.N_LANES(N), .SYNC_COUNT(SC), .MAX_RUN(0)) u_dut_nr (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [2:0] l;
    logic       act;
    logic       err;
  } exp_t;

  typedef struct {
    int   st;   // 0 = SYNC, 1 = RUN
    int   sc;
    int   rc;
    int   rr;
    exp_t o;
  } mdl_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  mdl_t ma, mb;
  exp_t qa[$], qb[$];
  logic va[$], vb[$];
  int   la[$];
  logic [7:0] da[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] lane_byte(input int i, input int t);
    return 8'(((i & 15) << 4) | (t & 15));
  endfunction

  task automatic set_traffic(input int t);
    for (int i = 0; i < N; i++) din[8*i +: 8] = lane_byte(i, t);
  endtask

  task automatic clear_obs();
    va.delete(); vb.delete(); la.delete(); da.delete();
  endtask

  // Spec-level cycle model: expected grant now, expected registered outputs next edge.
  task automatic model_step(inout mdl_t m, input int mr, input logic rst_i, output logic [3:0] g);
    int gi;
    logic [7:0] b;
    logic forced;
    g  = '0;
    gi = -1;
    if (rst_i) begin
      m.st = 0; m.sc = 0; m.rc = 0; m.rr = 0;
      m.o  = '{d: BC, v: 1'b0, l: 3'd0, act: 1'b0, err: 1'b0};
      return;
    end
    if (m.st == 1 && !rsy) begin
      forced = (mr != 0) && (m.rc == mr);
      if (!forced)
        for (int i = 0; i < N; i++) begin
          int k = (m.rr + i) % N;
          if (gi < 0 && vin[k]) gi = k;
        end
    end
    if (gi >= 0) g[gi] = 1'b1;
    if (rsy) begin
      m.st = 0; m.sc = 0; m.rc = 0;
      m.o.act = 1'b0; m.o.d = BC; m.o.v = 1'b0;
    end else if (m.st == 0) begin
      m.o.d = BC; m.o.v = 1'b0;
      if (m.sc == SC - 1) begin m.st = 1; m.sc = 0; m.o.act = 1'b1; end
      else m.sc++;
    end else if (gi >= 0) begin
      b      = din[8*gi +: 8];
      m.rr   = (gi + 1) % N;
      m.o.l  = 3'(gi);
      if (b == BC) begin
        m.o.d = BC; m.o.v = 1'b0; m.o.err = 1'b1; m.rc = 0;
      end else begin
        m.o.d = b; m.o.v = 1'b1; m.rc++;
      end
    end else begin
      m.o.d = BC; m.o.v = 1'b0; m.rc = 0;
    end
  endtask

  task automatic cmp(input string tag, input exp_t o, input exp_t e);
    check({tag, "_tx_data"},   32'(o.d),   32'(e.d));
    check({tag, "_tx_valid"},  32'(o.v),   32'(e.v));
    check({tag, "_tx_lane"},   32'(o.l),   32'(e.l));
    check({tag, "_active"},    32'(o.act), 32'(e.act));
    check({tag, "_err_comma"}, 32'(o.err), 32'(e.err));
  endtask

  // One clock: called at a falling edge with inputs already applied.
  task automatic cycle();
    logic [3:0] ga, gb;
    exp_t oa, ob, e;
    #1;
    model_step(ma, 16, reset, ga);
    model_step(mb, 0, reset, gb);
    check("grant_a", 32'(bus_a.grant), 32'(ga));
    check("grant_b", 32'(bus_b.grant), 32'(gb));
    qa.push_back(ma.o);
    qb.push_back(mb.o);
    @(posedge clk_4f);
    #1;
    oa = '{d: bus_a.tx_data, v: bus_a.tx_valid, l: bus_a.tx_lane, act: bus_a.active, err: bus_a.err_comma};
    ob = '{d: bus_b.tx_data, v: bus_b.tx_valid, l: bus_b.tx_lane, act: bus_b.active, err: bus_b.err_comma};
    if (qa.size() == 0) check("sb_a_empty", 32'd0, 32'd1);
    else begin e = qa.pop_front(); cmp("a", oa, e); end
    if (qb.size() == 0) check("sb_b_empty", 32'd0, 32'd1);
    else begin e = qb.pop_front(); cmp("b", ob, e); end
    va.push_back(oa.v);
    vb.push_back(ob.v);
    la.push_back(int'(oa.l));
    da.push_back(oa.d);
    @(negedge clk_4f);
  endtask

  // After reset release: four commas, then lane 0 data on the fifth output.
  task automatic check_preamble(input string tag, input int t_first);
    for (int i = 0; i < SC; i++) begin
      check({tag, "_pre_data"},  32'(da[i]), 32'(BC));
      check({tag, "_pre_valid"}, 32'(va[i]), 32'd0);
    end
    check({tag, "_first_valid"}, 32'(va[SC]), 32'd1);
    check({tag, "_first_lane"},  32'(la[SC]), 32'd0);
    check({tag, "_first_data"},  32'(da[SC]), 32'(lane_byte(0, t_first)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lead;
    int exp_l[$];

    reset = 1'b1;
    rsy   = 1'b0;
    vin   = '1;
    set_traffic(0);
    @(negedge clk_4f);
    cycle();
    cycle();

    // Preamble with all lanes requesting.
    reset = 1'b0;
    clear_obs();
    for (int t = 0; t < 6; t++) begin
      set_traffic(t);
      cycle();
    end
    check_preamble("rel", SC);

    // Lane 2 alone: 11, 22, 33.
    clear_obs();
    vin = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      set_traffic(t);
      din[8*2 +: 8] = 8'(8'h11 * (t + 1));
      cycle();
    end
    for (int t = 0; t < 3; t++) begin
      check("l2_data", 32'(da[t]), 32'(8'h11 * (t + 1)));
      check("l2_lane", 32'(la[t]), 32'd2);
    end

    // All lanes: rotation continues from lane 3; then lanes 1 and 3 only.
    clear_obs();
    vin = 4'b1111;
    for (int t = 0; t < 6; t++) begin set_traffic(t); cycle(); end
    vin = 4'b1010;
    for (int t = 0; t < 4; t++) begin set_traffic(t); cycle(); end
    exp_l = '{3, 0, 1, 2, 3, 0, 1, 3, 1, 3};
    foreach (exp_l[i]) check("rr_order", 32'(la[i]), 32'(exp_l[i]));

    // Quiet period: idles, run counter clears.
    vin = '0;
    cycle();
    cycle();

    // Continuous traffic: 16 bytes, one forced idle, resume at next lane.
    clear_obs();
    vin = '1;
    for (int t = 0; t < 20; t++) begin set_traffic(t); cycle(); end
    lead = 0;
    while (lead < va.size() && va[lead] === 1'b1) lead++;
    check("run_len", 32'(lead), 32'd16);
    check("forced_idle_data", 32'(da[16]), 32'(BC));
    check("resume_valid", 32'(va[17]), 32'd1);
    check("resume_lane", 32'(la[17]), 32'((la[15] + 1) % N));
    lead = 0;
    foreach (vb[i]) if (vb[i] === 1'b1) lead++;
    check("norun_all_valid", 32'(lead), 32'd20);

    // Resync held two cycles during traffic; rotation resumes from the old pointer.
    clear_obs();
    for (int t = 0; t < 11; t++) begin
      rsy = (t == 2 || t == 3);
      set_traffic(t);
      cycle();
    end
    rsy = 1'b0;
    for (int i = 2; i < 8; i++) check("resync_gap", 32'(va[i]), 32'd0);
    check("resync_resume", 32'(va[8]), 32'd1);
    check("resync_lane", 32'(la[8]), 32'((la[1] + 1) % N));

    // Lane 1 offers a comma as data.
    clear_obs();
    vin = 4'b0010;
    set_traffic(0);
    din[8*1 +: 8] = BC;
    cycle();
    vin = '1;
    for (int t = 1; t < 5; t++) begin set_traffic(t); cycle(); end
    check("comma_valid", 32'(va[0]), 32'd0);
    check("comma_data", 32'(da[0]), 32'(BC));
    check("comma_sticky_a", 32'(bus_a.err_comma), 32'd1);
    check("comma_sticky_b", 32'(bus_b.err_comma), 32'd1);

    // Asynchronous reset between edges during traffic.
    for (int t = 5; t < 8; t++) begin set_traffic(t); cycle(); end
    #3;
    reset = 1'b1;
    #1;
    check("arst_tx_data",  32'(bus_a.tx_data),   32'(BC));
    check("arst_tx_valid", 32'(bus_a.tx_valid),  32'd0);
    check("arst_tx_lane",  32'(bus_a.tx_lane),   32'd0);
    check("arst_active",   32'(bus_a.active),    32'd0);
    check("arst_err",      32'(bus_a.err_comma), 32'd0);
    check("arst_grant",    32'(bus_a.grant),     32'd0);
    check("arst_err_b",    32'(bus_b.err_comma), 32'd0);
    @(negedge clk_4f);
    cycle();
    cycle();
    reset = 1'b0;
    clear_obs();
    for (int t = 0; t < 6; t++) begin set_traffic(t); cycle(); end
    check_preamble("rerel", SC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
